ibexc_data_responder: RTL

- Memory-side responder for the CHERIoT core data interface (req/gnt/rvalid, 33-bit data with tag in bit 32).
- Grants core requests, drives a single-port tagged SRAM (fixed 1-cycle read latency) and returns in-order responses.
- Flags an error for out-of-range addresses.
- Used in core-level testbenches and the simple system as the data-side slave.

---
 rtl/ibexc_tb_pkg.sv | 12 +
 rtl/ibexc_rsp_fifo.sv | 60 ++++++
 rtl/ibexc_data_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ibexc_tb_pkg.sv
// Shared types for the CHERIoT data-side responder: response entry layout and tag position.
package ibexc_tb_pkg;

   localparam int unsigned RspDataWidth = 33;
   localparam int unsigned TagBit       = 32;

   typedef struct packed {
      logic                    err;
      logic [RspDataWidth-1:0] rdata;
   } rsp_entry_t;

endpackage

// File: rtl/ibexc_rsp_fifo.sv
// Synchronous response FIFO; head is visible on rdata_o whenever not empty.
module ibexc_rsp_fifo
   import ibexc_tb_pkg::*;
#(
   parameter int unsigned Depth   = 4,
   parameter type         entry_t = rsp_entry_t
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  entry_t                       wdata_i,
   input  logic                         pop_i,
   output entry_t                       rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   entry_t          mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [CntW-1:0] count;
   logic            do_push;
   logic            do_pop;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count == CntW'(Depth));
   assign empty_o = (count == '0);
   assign count_o = count;
   assign rdata_o = mem[rd_ptr];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CntW'(1);
         else if (do_pop && !do_push) count <= count - CntW'(1);
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/ibexc_data_responder.sv
// Data-side slave for the CHERIoT core: grants requests, drives a tagged 1-cycle SRAM,
// and returns in-order responses, erroring accesses outside the RAM window.
module ibexc_data_responder
   import ibexc_tb_pkg::*;
#(
   parameter logic [31:0] MemBase   = 32'h2000_0000,
   parameter logic [31:0] MemSize   = 32'h0001_0000,
   parameter int unsigned Depth     = 4,
   parameter int unsigned DataWidth = 33
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          data_req_i,
   input  logic                          data_is_cap_i,
   input  logic                          data_we_i,
   input  logic [3:0]                    data_be_i,
   input  logic [31:0]                   data_addr_i,
   input  logic [DataWidth-1:0]          data_wdata_i,
   output logic                          data_gnt_o,
   output logic                          data_rvalid_o,
   output logic [DataWidth-1:0]          data_rdata_o,
   output logic                          data_err_o,
   input  logic                          gnt_stall_i,
   input  logic                          rsp_stall_i,
   output logic                          ram_req_o,
   output logic                          ram_we_o,
   output logic [3:0]                    ram_be_o,
   output logic [$clog2(MemSize)-3:0]    ram_addr_o,
   output logic [DataWidth-1:0]          ram_wdata_o,
   input  logic [DataWidth-1:0]          ram_rdata_i
);

   localparam int unsigned RamAddrW = $clog2(MemSize) - 2;
   localparam int unsigned CntW     = $clog2(Depth + 1);

   logic [31:0]     offset;
   logic            in_range;
   logic            accept;
   logic            ram_access;
   logic [CntW-1:0] outstanding;

   logic            s1_valid;
   logic            s1_err;
   logic            s1_we;
   logic            s1_is_cap;

   rsp_entry_t      push_entry;
   rsp_entry_t      head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_count;

   // Wrapping subtraction makes addresses below MemBase land far out of range.
   assign offset     = data_addr_i - MemBase;
   assign in_range   = (offset < MemSize);
   assign data_gnt_o = data_req_i & ~gnt_stall_i & (outstanding < CntW'(Depth));
   assign accept     = data_req_i & data_gnt_o;
   assign ram_access = accept & in_range;

   assign ram_req_o  = ram_access;
   assign ram_we_o   = ram_access & data_we_i;
   assign ram_be_o   = ram_access ? data_be_i : '0;
   assign ram_addr_o = ram_access ? offset[RamAddrW+1:2] : '0;

   // Non-capability writes always store a cleared tag.
   always_comb begin
      ram_wdata_o = '0;
      if (ram_access) begin
         ram_wdata_o         = data_wdata_i;
         ram_wdata_o[TagBit] = data_wdata_i[TagBit] & data_is_cap_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid  <= 1'b0;
         s1_err    <= 1'b0;
         s1_we     <= 1'b0;
         s1_is_cap <= 1'b0;
      end else begin
         s1_valid  <= accept;
         s1_err    <= accept & ~in_range;
         s1_we     <= accept & data_we_i;
         s1_is_cap <= accept & data_is_cap_i;
      end
   end

   // Read data is captured the cycle after the RAM strobe; writes and errors return zero.
   always_comb begin
      push_entry     = '0;
      push_entry.err = s1_err;
      if (!s1_err && !s1_we) begin
         push_entry.rdata         = RspDataWidth'(ram_rdata_i);
         push_entry.rdata[TagBit] = ram_rdata_i[TagBit] & s1_is_cap;
      end
   end

   ibexc_rsp_fifo #(
      .Depth   (Depth),
      .entry_t (rsp_entry_t)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (s1_valid),
      .wdata_i (push_entry),
      .pop_i   (data_rvalid_o),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign data_rvalid_o = ~fifo_empty & ~rsp_stall_i;
   assign data_rdata_o  = fifo_empty ? '0 : DataWidth'(head.rdata);
   assign data_err_o    = ~fifo_empty & head.err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding <= '0;
      end else begin
         case ({accept, data_rvalid_o})
            2'b10:   outstanding <= outstanding + CntW'(1);
            2'b01:   outstanding <= outstanding - CntW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (data_req_i && !data_gnt_o) |=> (data_req_i &&
         $stable({data_we_i, data_is_cap_i, data_be_i, data_addr_i, data_wdata_i})));
   a_rvalid_has_txn: assert property (@(posedge clk_i) disable iff (!rst_ni)
      data_rvalid_o |-> (outstanding != '0));
   a_outstanding_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      outstanding <= CntW'(Depth));
   a_fifo_within_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (fifo_count <= outstanding) && !(s1_valid && fifo_full));

endmodule
